ife_commit_sequencer: RTL and testbench
=======================================

// Module: ife_commit_sequencer
// PURPOSE
//  Sequences speculative dual-core execution of instruction blocks and their verification.
//  Queues incoming block IDs and dispatches each block to core 0 and core 1 in parallel.
//  Waits for both cores to finish, then presents the block to ife_commit_unit for result comparison.
//  On mismatch or timeout it re-executes the block serially on core 0 only, then retires it.
// PARAMETERS
//  BLOCK_ID_WIDTH  8    width of block identifier
//  QUEUE_DEPTH     4    pending-block FIFO entries (power of 2, >=2)
//  TIMEOUT_CYCLES  256  max cycles waiting for core done before fallback (>=2)
//  FAIL_CNT_WIDTH  16   width of saturating fail counter
// PORTS
//  clk               in   1     clock
//  rst               in   1     synchronous reset, active-high
//  blk_valid         in   1     new block offered
//  blk_id            in   BIW   block ID offered
//  blk_ready         out  1     queue can accept (not full)
//  core0_start       out  1     1-cycle start pulse, core 0
//  core1_start       out  1     1-cycle start pulse, core 1
//  core_serial       out  1     1 = current dispatch is serial re-execution
//  core_block_id     out  BIW   block ID for the current dispatch
//  core0_done        in   1     core 0 finished (pulse)
//  core1_done        in   1     core 1 finished (pulse)
//  valid_in          out  1     drives ife_commit_unit.valid_in
//  block_id          out  BIW   drives ife_commit_unit.block_id
//  commit_ok         in   1     from ife_commit_unit
//  commit_fail       in   1     from ife_commit_unit
//  retire_valid      out  1     1-cycle pulse: block retired
//  retire_block_id   out  BIW   retired block ID
//  retire_serial     out  1     retired via serial path
//  retire_error      out  1     serial path also timed out
//  fail_count        out  FCW   saturating count of serial fallbacks
//  busy              out  1     state != IDLE or queue non-empty
// BEHAVIOUR
//  Reset: all outputs 0 except blk_ready=1; queue empty; state IDLE; fail_count=0.
//  Queue push on blk_valid&&blk_ready. A push into a full queue cannot occur because blk_ready=0.
//  A pop in the same cycle does not free a slot for a push in that cycle.
//  FSM:
//   IDLE     -> DISPATCH when queue non-empty; pops the head into cur_id.
//   DISPATCH -> WAIT; drives core0_start=core1_start=1, core_serial=0.
//               Clears done flags and the timeout counter.
//   WAIT     -> COMPARE when d0&&d1.
//               d0/d1 are sticky flags set by the done pulses; the pulses may arrive in either order or together.
//            -> SDISPATCH when counter reaches TIMEOUT_CYCLES-1 without both flags set.
//   COMPARE  -> valid_in=1 and block_id=cur_id for exactly 1 cycle.
//               commit_ok -> RETIRE (serial=0).
//               commit_fail, or neither input asserted -> SDISPATCH.
//   SDISPATCH-> SWAIT; drives core0_start=1, core1_start=0, core_serial=1.
//               Increments fail_count (saturates at all-ones).
//   SWAIT    -> RETIRE (serial=1) on core0_done.
//            -> RETIRE (serial=1, error=1) on timeout.
//   RETIRE   -> IDLE; retire_valid=1 for 1 cycle.
//  Timing: a block accepted into an empty queue while in IDLE is popped the next cycle.
//   core*_start fires the cycle after the pop.
//   Minimum accept-to-retire time is 5 cycles (done in the cycle after start).
//  Done pulses outside WAIT/SWAIT are ignored. core1_done in SWAIT is ignored.
//  core_block_id holds cur_id from DISPATCH through RETIRE.
//  All FSM outputs are registered decodes of state; no combinational input->output paths.
//  Mid-operation reset: state returns to IDLE and the queue is flushed; no retire is emitted.
// STRUCTURE
//  ife_pkg: typedef ife_seq_state_e (IDLE, DISPATCH, WAIT, COMPARE, SDISPATCH, SWAIT, RETIRE).
//  ife_pkg also holds the block_id_t typedef.
//  Sub-module ife_block_queue: synchronous FIFO with push/pop, full/empty, and pointer wrap.
//  FSM, timeout counter and fail counter live in ife_commit_sequencer.
// TESTING
//  1. Push id 0x11; done0 and done1 together 3 cycles after start; commit_ok.
//     -> retire 0x11, serial=0, error=0; fail_count=0.
//  2. Push id 0x22; done1 then done0 5 cycles later; commit_fail.
//     -> core0_start with core_serial=1; done0 -> retire 0x22, serial=1; fail_count=1.
//  3. Push 5 ids back-to-back with QUEUE_DEPTH=4 while a block is stalled.
//     -> blk_ready drops after the 4th; all 5 retire in push order after draining.
//  4. No done from core1 -> after TIMEOUT_CYCLES in WAIT, serial dispatch.
//     No done again -> retire with error=1.
//  5. Assert rst in WAIT with 2 blocks queued.
//     -> next cycle all outputs at reset values; busy=0; no retire_valid pulse.
//  6. Force fail_count to max, then cause a fallback -> fail_count stays all-ones.

Source files
------------

// File: rtl/ife_pkg.sv
// Shared types for the IFE commit sequencer: sequencer states and the default block identifier type.
package ife_pkg;

  localparam int IFE_BLOCK_ID_WIDTH = 8;

  typedef logic [IFE_BLOCK_ID_WIDTH-1:0] block_id_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT,
    COMPARE,
    SDISPATCH,
    SWAIT,
    RETIRE
  } ife_seq_state_e;

endpackage

// File: rtl/ife_block_queue.sv
// Pending-block FIFO. Occupancy comes from a registered count, so a pop never frees a slot
// for a push in the same cycle.
module ife_block_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ife_commit_sequencer.sv
// Dispatches queued blocks to both cores, hands finished blocks to the commit unit, and falls back
// to serial re-execution on core 0 when the results disagree or a core never finishes.
module ife_commit_sequencer
  import ife_pkg::*;
#(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int FAIL_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_valid,
  input  logic [BLOCK_ID_WIDTH-1:0] blk_id,
  output logic                      blk_ready,
  output logic                      core0_start,
  output logic                      core1_start,
  output logic                      core_serial,
  output logic [BLOCK_ID_WIDTH-1:0] core_block_id,
  input  logic                      core0_done,
  input  logic                      core1_done,
  output logic                      valid_in,
  output logic [BLOCK_ID_WIDTH-1:0] block_id,
  input  logic                      commit_ok,
  input  logic                      commit_fail,
  output logic                      retire_valid,
  output logic [BLOCK_ID_WIDTH-1:0] retire_block_id,
  output logic                      retire_serial,
  output logic                      retire_error,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count,
  output logic                      busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ife_seq_state_e state, next_state;

  logic [BLOCK_ID_WIDTH-1:0] cur_id;
  logic [BLOCK_ID_WIDTH-1:0] q_head;
  logic                      q_full;
  logic                      q_empty;
  logic                      q_push;
  logic                      q_pop;
  logic                      d0, d1;
  logic                      d0_now, d1_now;
  logic [CNT_W-1:0]          tmo_cnt;
  logic                      timeout;
  logic                      ret_serial;
  logic                      ret_error;

  assign blk_ready = !q_full;
  assign q_push    = blk_valid && blk_ready;
  assign q_pop     = (state == IDLE) && !q_empty;

  ife_block_queue #(
    .WIDTH (BLOCK_ID_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (blk_id),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // A done pulse counts in the cycle it arrives, so simultaneous pulses complete at once.
  assign d0_now  = d0 || core0_done;
  assign d1_now  = d1 || core1_done;
  assign timeout = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_id     <= '0;
      d0         <= 1'b0;
      d1         <= 1'b0;
      tmo_cnt    <= '0;
      fail_count <= '0;
      ret_serial <= 1'b0;
      ret_error  <= 1'b0;
    end else begin
      state <= next_state;
      if (q_pop) begin
        cur_id <= q_head;
      end
      case (state)
        DISPATCH: begin
          d0      <= 1'b0;
          d1      <= 1'b0;
          tmo_cnt <= '0;
        end
        WAIT: begin
          d0      <= d0_now;
          d1      <= d1_now;
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
        COMPARE: begin
          ret_serial <= 1'b0;
          ret_error  <= 1'b0;
        end
        SDISPATCH: begin
          tmo_cnt <= '0;
          if (fail_count != '1) begin
            fail_count <= fail_count + FAIL_CNT_WIDTH'(1);
          end
        end
        SWAIT: begin
          tmo_cnt    <= tmo_cnt + CNT_W'(1);
          ret_serial <= 1'b1;
          ret_error  <= !core0_done;
        end
        default: ;
      endcase
    end
  end

  // A commit unit that flags both ok and fail is treated as a mismatch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!q_empty) next_state = DISPATCH;
      DISPATCH:  next_state = WAIT;
      WAIT: begin
        if (d0_now && d1_now) begin
          next_state = COMPARE;
        end else if (timeout) begin
          next_state = SDISPATCH;
        end
      end
      COMPARE:   next_state = (commit_ok && !commit_fail) ? RETIRE : SDISPATCH;
      SDISPATCH: next_state = SWAIT;
      SWAIT:     if (core0_done || timeout) next_state = RETIRE;
      RETIRE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  assign core0_start     = (state == DISPATCH) || (state == SDISPATCH);
  assign core1_start     = (state == DISPATCH);
  assign core_serial     = (state == SDISPATCH) || (state == SWAIT);
  assign core_block_id   = (state != IDLE) ? cur_id : '0;
  assign valid_in        = (state == COMPARE);
  assign block_id        = valid_in ? cur_id : '0;
  assign retire_valid    = (state == RETIRE);
  assign retire_block_id = retire_valid ? cur_id : '0;
  assign retire_serial   = retire_valid && ret_serial;
  assign retire_error    = retire_valid && ret_error;
  assign busy            = (state != IDLE) || !q_empty;

endmodule

// File: tb/tb_ife_commit_sequencer.sv
// Scoreboard bench: a behavioural core/commit-unit responder plays per-block scripts, and the
// predicted retire records are queued at push time and compared as blocks retire.
module tb_ife_commit_sequencer;

  localparam int BIW = 8;
  localparam int QD  = 4;
  localparam int TMO = 16;
  localparam int FCW = 3;
  localparam logic [FCW-1:0] FC_MAX = '1;

  typedef struct {
    logic [BIW-1:0] id;
    logic           serial;
    logic           error;
    logic [FCW-1:0] fc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           blk_valid = 1'b0;
  logic [BIW-1:0] blk_id = '0;
  logic           blk_ready;
  logic           core0_start, core1_start, core_serial;
  logic [BIW-1:0] core_block_id;
  logic           core0_done = 1'b0;
  logic           core1_done = 1'b0;
  logic           valid_in;
  logic [BIW-1:0] block_id;
  logic           commit_ok = 1'b0;
  logic           commit_fail = 1'b0;
  logic           retire_valid;
  logic [BIW-1:0] retire_block_id;
  logic           retire_serial, retire_error;
  logic [FCW-1:0] fail_count;
  logic           busy;

  int testCount = 0;
  int failCount = 0;

  exp_t           sb[$];
  logic [FCW-1:0] modelFc = '0;

  int behD0  [256];
  int behD1  [256];
  int behCmt [256];
  int behSd0 [256];

  ife_commit_sequencer #(
    .BLOCK_ID_WIDTH (BIW),
    .QUEUE_DEPTH    (QD),
    .TIMEOUT_CYCLES (TMO),
    .FAIL_CNT_WIDTH (FCW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .blk_valid       (blk_valid),
    .blk_id          (blk_id),
    .blk_ready       (blk_ready),
    .core0_start     (core0_start),
    .core1_start     (core1_start),
    .core_serial     (core_serial),
    .core_block_id   (core_block_id),
    .core0_done      (core0_done),
    .core1_done      (core1_done),
    .valid_in        (valid_in),
    .block_id        (block_id),
    .commit_ok       (commit_ok),
    .commit_fail     (commit_fail),
    .retire_valid    (retire_valid),
    .retire_block_id (retire_block_id),
    .retire_serial   (retire_serial),
    .retire_error    (retire_error),
    .fail_count      (fail_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic bit inWindow(input int d);
    return (d >= 1) && (d <= TMO);
  endfunction

  // Scripts the cores/commit unit for a block, predicts its retire record, then offers it.
  task automatic applyStimulus(input logic [BIW-1:0] id, input int d0, input int d1,
                               input int cmt, input int sd0, input bit track);
    exp_t e;
    int   n;
    behD0[id]  = d0;
    behD1[id]  = d1;
    behCmt[id] = cmt;
    behSd0[id] = sd0;
    if (track) begin
      e.id = id;
      if (inWindow(d0) && inWindow(d1) && cmt == 1) begin
        e.serial = 1'b0;
        e.error  = 1'b0;
      end else begin
        if (modelFc != FC_MAX) modelFc = modelFc + 1'b1;
        e.serial = 1'b1;
        e.error  = !inWindow(sd0);
      end
      e.fc = modelFc;
      sb.push_back(e);
    end
    n = 0;
    while (!blk_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) begin
      checkOutput("push_ready_timeout", 32'd0, 32'd1);
    end else begin
      blk_valid = 1'b1;
      blk_id    = id;
      @(negedge clk);
      blk_valid = 1'b0;
    end
  endtask

  task automatic waitStart(input string tag);
    int n = 0;
    while (!core0_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!core0_start) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
  endtask

  // Core and commit-unit responder: starts are detected mid-cycle and done pulses are
  // scheduled as a count of cycles after the start cycle.
  int  cyc = 0;
  bit  parAct = 0, serAct = 0;
  int  parEl = 0, serEl = 0;
  int  parD0 = 0, parD1 = 0, serD0 = 0, parCyc = 0;
  logic [BIW-1:0] parId = '0;

  always @(negedge clk) begin
    int expGap;
    cyc++;
    core0_done = 1'b0;
    core1_done = 1'b0;
    if (parAct) begin
      parEl++;
      if (parEl == parD0) core0_done = 1'b1;
      if (parEl == parD1) core1_done = 1'b1;
    end
    if (serAct) begin
      serEl++;
      if (serEl == serD0) core0_done = 1'b1;
    end
    commit_ok   = valid_in && (behCmt[block_id] == 1);
    commit_fail = valid_in && (behCmt[block_id] == 2);
    if (valid_in) checkOutput("compare_id", 32'(block_id), 32'(parId));
    if (core1_start && !core0_start) checkOutput("core1_alone", 32'd1, 32'd0);
    if (core0_start) begin
      checkOutput("start_pair", {31'd0, core1_start}, {31'd0, !core_serial});
      if (!core_serial) begin
        parAct = 1; serAct = 0; parEl = 0;
        parId  = core_block_id;
        parD0  = behD0[core_block_id];
        parD1  = behD1[core_block_id];
        parCyc = cyc;
      end else begin
        checkOutput("serial_id", 32'(core_block_id), 32'(parId));
        expGap = (inWindow(parD0) && inWindow(parD1)) ?
                 ((parD0 > parD1 ? parD0 : parD1) + 2) : (TMO + 1);
        checkOutput("serial_gap", 32'(cyc - parCyc), 32'(expGap));
        serAct = 1; parAct = 0; serEl = 0;
        serD0  = behSd0[core_block_id];
      end
    end
  end

  // Retire monitor: every retire must match the oldest predicted record.
  always @(negedge clk) begin
    exp_t e;
    if (retire_valid) begin
      if (sb.size() == 0) begin
        checkOutput("retire_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("retire_id", 32'(retire_block_id), 32'(e.id));
        checkOutput("retire_serial", {31'd0, retire_serial}, {31'd0, e.serial});
        checkOutput("retire_error", {31'd0, retire_error}, {31'd0, e.error});
        checkOutput("fail_count", 32'(fail_count), 32'(e.fc));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_blk_ready"}, {31'd0, blk_ready}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    checkOutput({tag, "_starts"}, {29'd0, core0_start, core1_start, core_serial}, 32'd0);
    checkOutput({tag, "_valid_in"}, {31'd0, valid_in}, 32'd0);
    checkOutput({tag, "_retire"}, {31'd0, retire_valid}, 32'd0);
    checkOutput({tag, "_ids"}, {8'd0, core_block_id, block_id, retire_block_id}, 32'd0);
  endtask

  // Measures cycles from the pop cycle (where applyStimulus returns) to the retire pulse.
  task automatic checkLatency(input string tag, input int expected);
    int n = 0;
    checkOutput({tag, "_no_start_in_pop"}, {31'd0, core0_start}, 32'd0);
    while (!retire_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n), 32'(expected));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetValues("reset");

    // Parallel success, both dones together three cycles after start.
    applyStimulus(8'h11, 3, 3, 1, 1, 1'b1);
    @(negedge clk);
    checkOutput("start_after_pop", {31'd0, core0_start}, 32'd1);
    waitDrain();

    // Minimum path: accept in cycle 0 retires in cycle 5.
    applyStimulus(8'h12, 1, 1, 1, 1, 1'b1);
    checkLatency("min_latency", 4);
    waitDrain();

    // Done pulses in opposite order, then a commit mismatch forces serial re-execution.
    applyStimulus(8'h22, 7, 2, 2, 2, 1'b1);
    waitDrain();

    // Fill the queue behind a stalled block; the fifth push must wait.
    applyStimulus(8'h30, 12, 12, 1, 1, 1'b1);
    waitStart("stall_start");
    for (int i = 1; i <= 4; i++) applyStimulus(8'(8'h30 + i), 1, 1, 1, 1, 1'b1);
    checkOutput("queue_full_ready", {31'd0, blk_ready}, 32'd0);
    applyStimulus(8'h35, 1, 1, 1, 1, 1'b1);
    waitDrain();

    // Core 1 never finishes, and the serial retry never finishes either.
    applyStimulus(8'h40, 2, -1, 1, -1, 1'b1);
    waitDrain();

    // Repeated fallbacks, including a silent commit unit, drive fail_count into saturation.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8'(8'h50 + i), 1, 1, (i == 1) ? 0 : 2, 1, 1'b1);
    end
    waitDrain();
    checkOutput("fail_count_saturated", 32'(fail_count), 32'(FC_MAX));

    // Reset while waiting with two blocks queued: no retire, everything back to idle.
    applyStimulus(8'h60, -1, -1, 1, -1, 1'b0);
    waitStart("reset_block_start");
    applyStimulus(8'h61, 1, 1, 1, 1, 1'b0);
    applyStimulus(8'h62, 1, 1, 1, 1, 1'b0);
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelFc = '0;
    checkResetValues("midreset");
    repeat (40) @(negedge clk);
    checkOutput("post_reset_idle", {31'd0, busy}, 32'd0);

    // Normal operation resumes after the flush.
    applyStimulus(8'h70, 2, 1, 1, 1, 1'b1);
    waitDrain();
    checkOutput("final_fail_count", 32'(fail_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
